avalon_reg_export: RTL and testbench

- Parametrised Avalon-MM slave register bank for coprocessor peripherals in the lab SoC, e.g. the AES accelerator.
- Holds NUM_REGS words written by the Nios II and drives a start/busy/done handshake to an attached core.
- Accepts result write-back from the core and drives a registered export word to top-level display logic.
- Generalises the single fixed 32-bit export to configurable width, depth and export index, and adds a control handshake.

---
 rtl/avl_reg_pkg.sv | 26 ++
 rtl/avl_reg_ctrl_fsm.sv | 64 ++++++
 rtl/avalon_reg_export.sv | 136 +++++++++++++
 tb/tb_avalon_reg_export.sv | 273 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/avl_reg_pkg.sv
`default_nettype none
// ============================================================================
// Module      : avl_reg_pkg
// Description : Shared types and bit positions for the Avalon register bank
//               and its start/busy/done control FSM.
// Revision    : 1.0 - initial release
// ============================================================================
package avl_reg_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    BUSY  = 2'd2,
    DONE  = 2'd3
  } ctrl_state_t;

  // Control register (START_IDX) bits
  localparam int START_BIT = 0;
  localparam int IRQEN_BIT = 2;

  // Status register (STATUS_IDX) bits
  localparam int DONE_BIT  = 0;
  localparam int BUSY_BIT  = 1;

endpackage
`default_nettype wire

// File: rtl/avl_reg_ctrl_fsm.sv
`default_nettype none
// ============================================================================
// Module      : avl_reg_ctrl_fsm
// Description : Start/busy/done handshake to the attached core. Optional IRQ
//               output is built when AVL_REG_IRQ_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
module avl_reg_ctrl_fsm
  import avl_reg_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic start_wr,    // bus write to the control reg with byte0 enabled
  input  logic start_wbit,  // start bit value carried by that write
  input  logic start_cur,   // start bit currently stored
  input  logic w1c_done,    // bus write-1-to-clear on the done bit
  input  logic core_done,
`ifdef AVL_REG_IRQ_EN
  input  logic irq_en,
  output logic irq,
`endif
  output logic core_start,
  output logic busy,
  output logic done
);

  ctrl_state_t state_q, state_d;

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      // Only a 0->1 transition of the stored start bit launches the core
      IDLE:    if (start_wr && start_wbit && !start_cur) state_d = START;
      START:   state_d = BUSY;
      BUSY:    if (core_done) state_d = DONE;
      DONE:    if (w1c_done) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  assign core_start = (state_q == START);
  assign busy       = (state_q == START) || (state_q == BUSY);
  assign done       = (state_q == DONE);

`ifdef AVL_REG_IRQ_EN
  logic irq_q, irq_d;

  always_comb irq_d = done && irq_en;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) irq_q <= 1'b0;
    else     irq_q <= irq_d;
  end

  assign irq = irq_q;
`endif

endmodule
`default_nettype wire

// File: rtl/avalon_reg_export.sv
`default_nettype none
// ============================================================================
// Module      : avalon_reg_export
// Description : Avalon-MM slave register bank with core result write-back,
//               start/busy/done handshake and a registered export word.
//               Define AVL_REG_IRQ_EN to add the IRQ output.
// Revision    : 1.0 - initial release
// ============================================================================
module avalon_reg_export
  import avl_reg_pkg::*;
#(
  parameter int NUM_REGS   = 16,
  parameter int DATA_W     = 32,
  parameter int ADDR_W     = $clog2(NUM_REGS),
  parameter int START_IDX  = NUM_REGS - 2,
  parameter int STATUS_IDX = NUM_REGS - 1,
  parameter int EXPORT_IDX = 0
) (
  input  logic                       CLK,
  input  logic                       RESET,
  input  logic                       AVL_CS,
  input  logic                       AVL_READ,
  input  logic                       AVL_WRITE,
  input  logic [ADDR_W-1:0]          AVL_ADDR,
  input  logic [DATA_W/8-1:0]        AVL_BYTE_EN,
  input  logic [DATA_W-1:0]          AVL_WRITEDATA,
  output logic [DATA_W-1:0]          AVL_READDATA,
  output logic                       AVL_READDATAVALID,
  output logic                       CORE_START,
  input  logic                       CORE_DONE,
  input  logic                       CORE_WE,
  input  logic [ADDR_W-1:0]          CORE_IDX,
  input  logic [DATA_W-1:0]          CORE_WDATA,
  output logic [NUM_REGS*DATA_W-1:0] REGS_FLAT,
  output logic [DATA_W-1:0]          EXPORT_DATA
`ifdef AVL_REG_IRQ_EN
  ,
  output logic                       IRQ
`endif
);

  localparam int                NUM_BYTES     = DATA_W / 8;
  localparam logic [ADDR_W-1:0] c_start_addr  = ADDR_W'(START_IDX);
  localparam logic [ADDR_W-1:0] c_status_addr = ADDR_W'(STATUS_IDX);

  logic [DATA_W-1:0] reg_q    [NUM_REGS];
  logic [DATA_W-1:0] reg_d    [NUM_REGS];
  logic [DATA_W-1:0] reg_view [NUM_REGS];

  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic              rvalid_q, rvalid_d;
  logic [DATA_W-1:0] export_q, export_d;

  logic              bus_wr, bus_rd, core_wr_ok, bus_wr_ok;
  logic              start_wr, w1c_done, busy, done;
  logic [DATA_W-1:0] merged, status_word;

  assign bus_wr     = AVL_CS && AVL_WRITE;
  assign bus_rd     = AVL_CS && AVL_READ;
  assign core_wr_ok = CORE_WE && (CORE_IDX != c_start_addr) && (CORE_IDX != c_status_addr);
  // A colliding core write wins; the status word is never loaded from the bus
  assign bus_wr_ok  = bus_wr && (AVL_ADDR != c_status_addr) &&
                      !(core_wr_ok && (CORE_IDX == AVL_ADDR));
  assign start_wr   = bus_wr && (AVL_ADDR == c_start_addr) && AVL_BYTE_EN[0];
  assign w1c_done   = bus_wr && (AVL_ADDR == c_status_addr) && AVL_BYTE_EN[0] &&
                      AVL_WRITEDATA[DONE_BIT];

  always_comb begin
    merged = reg_q[AVL_ADDR];
    for (int b = 0; b < NUM_BYTES; b++) begin
      if (AVL_BYTE_EN[b]) merged[b*8 +: 8] = AVL_WRITEDATA[b*8 +: 8];
    end
  end

  always_comb begin
    for (int i = 0; i < NUM_REGS; i++) reg_d[i] = reg_q[i];
    if (bus_wr_ok)  reg_d[AVL_ADDR] = merged;
    if (core_wr_ok) reg_d[CORE_IDX] = CORE_WDATA;
  end

  always_comb begin
    status_word           = '0;
    status_word[BUSY_BIT] = busy;
    status_word[DONE_BIT] = done;
  end

  // The status slot shows live handshake flags rather than stored data
  for (genvar i = 0; i < NUM_REGS; i++) begin : g_view
    assign reg_view[i]                   = (i == STATUS_IDX) ? status_word : reg_q[i];
    assign REGS_FLAT[i*DATA_W +: DATA_W] = reg_view[i];
  end

  // ADDR_W spans exactly NUM_REGS words, so every address is in range
  always_comb begin
    rvalid_d = bus_rd;
    rdata_d  = bus_rd ? reg_view[AVL_ADDR] : rdata_q;
    export_d = reg_q[EXPORT_IDX];
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      for (int i = 0; i < NUM_REGS; i++) reg_q[i] <= '0;
      rdata_q  <= '0;
      rvalid_q <= 1'b0;
      export_q <= '0;
    end else begin
      for (int i = 0; i < NUM_REGS; i++) reg_q[i] <= reg_d[i];
      rdata_q  <= rdata_d;
      rvalid_q <= rvalid_d;
      export_q <= export_d;
    end
  end

  avl_reg_ctrl_fsm u_ctrl (
    .clk        (CLK),
    .rst        (RESET),
    .start_wr   (start_wr),
    .start_wbit (AVL_WRITEDATA[START_BIT]),
    .start_cur  (reg_q[START_IDX][START_BIT]),
    .w1c_done   (w1c_done),
    .core_done  (CORE_DONE),
`ifdef AVL_REG_IRQ_EN
    .irq_en     (reg_q[START_IDX][IRQEN_BIT]),
    .irq        (IRQ),
`endif
    .core_start (CORE_START),
    .busy       (busy),
    .done       (done)
  );

  assign AVL_READDATA      = rdata_q;
  assign AVL_READDATAVALID = rvalid_q;
  assign EXPORT_DATA       = export_q;

endmodule
`default_nettype wire

// File: tb/tb_avalon_reg_export.sv
`default_nettype none
// ============================================================================
// Module      : tb_avalon_reg_export
// Description : Scoreboard bench for avalon_reg_export with a register-level
//               reference model; handles builds with or without AVL_REG_IRQ_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_avalon_reg_export;

  localparam int NR = 16;
  localparam int DW = 32;
  localparam int AW = 4;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic           cs = 1'b0, rd = 1'b0, wr = 1'b0;
  logic [AW-1:0]  addr = '0;
  logic [3:0]     be = '0;
  logic [DW-1:0]  wdata = '0;
  logic [DW-1:0]  rdata;
  logic           rvalid, core_start;
  logic           core_done = 1'b0, core_we = 1'b0;
  logic [AW-1:0]  core_idx = '0;
  logic [DW-1:0]  core_wdata = '0;
  logic [NR*DW-1:0] regs_flat;
  logic [DW-1:0]  export_data;
`ifdef AVL_REG_IRQ_EN
  logic           irq;
`endif

  avalon_reg_export dut (
    .CLK               (clk),
    .RESET             (rst),
    .AVL_CS            (cs),
    .AVL_READ          (rd),
    .AVL_WRITE         (wr),
    .AVL_ADDR          (addr),
    .AVL_BYTE_EN       (be),
    .AVL_WRITEDATA     (wdata),
    .AVL_READDATA      (rdata),
    .AVL_READDATAVALID (rvalid),
    .CORE_START        (core_start),
    .CORE_DONE         (core_done),
    .CORE_WE           (core_we),
    .CORE_IDX          (core_idx),
    .CORE_WDATA        (core_wdata),
    .REGS_FLAT         (regs_flat),
    .EXPORT_DATA       (export_data)
`ifdef AVL_REG_IRQ_EN
    ,
    .IRQ               (irq)
`endif
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  int cyc   = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Reference model: register contents, handshake phase, expected outputs
  logic [DW-1:0] m_reg [NR];
  int            m_phase;   // 0 idle, 1 start pulse, 2 busy, 3 done
  logic          m_irq;
  logic [DW-1:0] m_exp;
  logic [DW-1:0] rd_q [$];
  int            start_q [$];

  task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic fail_now(input string name);
    tests++;
    fails++;
    $display("FAIL %s: got unexpected event expected none (t=%0t)", name, $time);
  endtask

  task automatic model_reset();
    for (int i = 0; i < NR; i++) m_reg[i] = '0;
    m_phase = 0;
    m_irq   = 1'b0;
    m_exp   = '0;
    rd_q.delete();
    start_q.delete();
  endtask

  // Apply one cycle of stimulus, predict its effects, then check after the edge
  task automatic drive(input logic c, input logic r, input logic w, input logic [AW-1:0] a,
                       input logic [3:0] b, input logic [DW-1:0] d, input logic cd,
                       input logic cw, input logic [AW-1:0] ci, input logic [DW-1:0] cwd);
    logic [DW-1:0] mask;
    logic          busy, done, core_ok, bus_ok, trig, w1c;
    int            nphase, k;
    cs = c; rd = r; wr = w; addr = a; be = b; wdata = d;
    core_done = cd; core_we = cw; core_idx = ci; core_wdata = cwd;

    busy = (m_phase == 1) || (m_phase == 2);
    done = (m_phase == 3);
    if (c && r) rd_q.push_back((a == 4'd15) ? {30'b0, busy, done} : m_reg[a]);
    core_ok = cw && (ci != 4'd14) && (ci != 4'd15);
    bus_ok  = c && w && (a != 4'd15) && !(core_ok && (ci == a));
    trig    = c && w && (a == 4'd14) && b[0] && d[0] && !m_reg[14][0];
    w1c     = c && w && (a == 4'd15) && b[0] && d[0];
    nphase  = m_phase;
    case (m_phase)
      0: if (trig) begin nphase = 1; start_q.push_back(cyc + 1); end
      1: nphase = 2;
      2: if (cd) nphase = 3;
      default: if (w1c) nphase = 0;
    endcase
    m_irq = done && m_reg[14][2];
    m_exp = m_reg[0];
    mask = '0;
    for (int i = 0; i < 4; i++) if (b[i]) mask = mask | (32'hFF << (8 * i));
    if (bus_ok)  m_reg[a] = (m_reg[a] & ~mask) | (d & mask);
    if (core_ok) m_reg[ci] = cwd;
    m_phase = nphase;

    @(posedge clk);
    #1;
    check("export_data", export_data, m_exp);
`ifdef AVL_REG_IRQ_EN
    check("irq", {31'b0, irq}, {31'b0, m_irq});
`endif
    k = $urandom_range(0, 14);
    check($sformatf("regs_flat[%0d]", k), regs_flat[k*DW +: DW], m_reg[k]);
  endtask

  task automatic idle();
    drive(0, 0, 0, '0, '0, '0, 0, 0, '0, '0);
  endtask

  task automatic bus_wr(input logic [AW-1:0] a, input logic [3:0] b, input logic [DW-1:0] d);
    drive(1, 0, 1, a, b, d, 0, 0, '0, '0);
  endtask

  task automatic bus_rd(input logic [AW-1:0] a);
    drive(1, 1, 0, a, '0, '0, 0, 0, '0, '0);
  endtask

  task automatic done_pulse();
    drive(0, 0, 0, '0, '0, '0, 1, 0, '0, '0);
  endtask

  // Reset asserted between edges; outputs must clear without waiting for a clock
  task automatic mid_reset(input string tag);
    #2;
    rst = 1'b1;
    #1;
    check({tag, "_core_start"}, {31'b0, core_start}, 32'h0);
    check({tag, "_rvalid"}, {31'b0, rvalid}, 32'h0);
    check({tag, "_rdata"}, rdata, 32'h0);
    check({tag, "_export"}, export_data, 32'h0);
    check({tag, "_regs_flat14"}, regs_flat[14*DW +: DW], 32'h0);
`ifdef AVL_REG_IRQ_EN
    check({tag, "_irq"}, {31'b0, irq}, 32'h0);
`endif
    model_reset();
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  // Scoreboard monitor: pops expectations whenever the DUT presents an output
  always @(negedge clk) begin
    if (!rst) begin
      if (rvalid) begin
        if (rd_q.size() == 0) fail_now("readdatavalid_unexpected");
        else check("readdata", rdata, rd_q.pop_front());
      end
      if (core_start) begin
        if (start_q.size() == 0) fail_now("core_start_unexpected");
        else check("core_start_cycle", cyc, start_q.pop_front());
      end
    end
  end

  initial begin
    logic [AW-1:0] ra, ci;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check("reset_rdata", rdata, 32'h0);
    check("reset_rvalid", {31'b0, rvalid}, 32'h0);
    check("reset_core_start", {31'b0, core_start}, 32'h0);
    check("reset_export", export_data, 32'h0);
    rst = 1'b0;

    for (int i = 0; i < NR; i++) bus_rd(AW'(i));
    idle();

    bus_wr(4'd0, 4'b0101, 32'hDEADBEEF);
    check("export_lag", export_data, 32'h0);
    bus_rd(4'd0);
    check("export_after_write", export_data, 32'h00AD00EF);

    bus_wr(4'd14, 4'hF, 32'h1);
    check("start_pulse_high", {31'b0, core_start}, 32'h1);
    idle();
    check("start_pulse_low", {31'b0, core_start}, 32'h0);
    bus_rd(4'd15);
    bus_wr(4'd14, 4'hF, 32'h1);
    idle();
    check("no_retrigger_busy", {31'b0, core_start}, 32'h0);
    done_pulse();
    bus_rd(4'd15);
    bus_wr(4'd15, 4'h1, 32'h1);
    bus_rd(4'd15);
    bus_wr(4'd14, 4'hF, 32'h0);
    bus_wr(4'd14, 4'hF, 32'h1);
    check("restart_pulse", {31'b0, core_start}, 32'h1);
    idle();
    done_pulse();
    bus_wr(4'd15, 4'h1, 32'h1);

    drive(1, 0, 1, 4'd3, 4'hF, 32'h2222, 0, 1, 4'd3, 32'h1111);
    drive(1, 0, 1, 4'd6, 4'hF, 32'h6666, 0, 1, 4'd5, 32'h5555);
    bus_rd(4'd3);
    bus_rd(4'd5);
    bus_rd(4'd6);

    bus_wr(4'd14, 4'hF, 32'h0);
    bus_wr(4'd14, 4'hF, 32'h5);
    idle();
    idle();
    done_pulse();
    idle();
    idle();
    bus_wr(4'd15, 4'h1, 32'h1);
    idle();
    idle();

    bus_wr(4'd14, 4'hF, 32'h0);
    bus_wr(4'd14, 4'hF, 32'h1);
    idle();
    idle();
    mid_reset("rst_busy");
    bus_rd(4'd15);
    bus_wr(4'd14, 4'hF, 32'h1);
    mid_reset("rst_start");
    bus_rd(4'd15);
    bus_rd(4'd14);
    idle();

    for (int n = 0; n < 800; n++) begin
      case ($urandom_range(0, 4))
        0: ra = 4'd0;
        1: ra = 4'd14;
        2: ra = 4'd15;
        default: ra = AW'($urandom_range(0, NR - 1));
      endcase
      ci = AW'($urandom_range(0, NR - 1));
      drive(($urandom_range(0, 3) != 0), $urandom_range(0, 1), $urandom_range(0, 1), ra,
            4'($urandom_range(0, 15)), $urandom, ($urandom_range(0, 3) == 0),
            ($urandom_range(0, 2) == 0), ci, $urandom);
    end

    repeat (3) idle();
    check("rd_queue_drained", rd_q.size(), 32'h0);
    check("start_queue_drained", start_q.size(), 32'h0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
